// File: rtl/temp_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : temp_mon_pkg
//  Purpose  : Shared FSM encoding and DS18B20 conversion helpers for temp_monitor.
//  Revision : 1.0
// ============================================================================
package temp_mon_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      WAIT   = 3'd2,
      PROC   = 3'd3,
      UPDATE = 3'd4,
      FAIL   = 3'd5
   } state_t;

   // Value the DS18B20 reports before its first real conversion (85 C).
   localparam logic [15:0] RAW_POR = 16'h0550;

   function automatic logic signed [7:0] raw_to_c(input logic [15:0] raw);
      logic signed [16:0] sum;
      logic signed [16:0] shr;
      sum = $signed({raw[15], raw}) + 17'sd8;
      shr = sum >>> 4;
      if (shr > 17'sd127)
         return 8'sd127;
      else if (shr < -17'sd128)
         return -8'sd128;
      else
         return shr[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/temp_ms_timer.sv
`default_nettype none
// ============================================================================
//  Module   : temp_ms_timer
//  Purpose  : Free-running microsecond and millisecond tick pulse generator.
//  Revision : 1.0
// ============================================================================
module temp_ms_timer #(
   parameter int FCLK      = 125,
   parameter int US_PER_MS = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic us_tick,
   output logic ms_tick
);

   localparam int c_us_w = $clog2(FCLK + 1);
   localparam int c_ms_w = $clog2(US_PER_MS + 1);

   logic [c_us_w-1:0] us_cnt_q, us_cnt_d;
   logic [c_ms_w-1:0] ms_cnt_q, ms_cnt_d;

   always_comb begin
      us_tick  = (us_cnt_q == c_us_w'(FCLK - 1));
      ms_tick  = us_tick && (ms_cnt_q == c_ms_w'(US_PER_MS - 1));
      us_cnt_d = us_tick ? '0 : us_cnt_q + c_us_w'(1);
      ms_cnt_d = ms_cnt_q;
      if (ms_tick)
         ms_cnt_d = '0;
      else if (us_tick)
         ms_cnt_d = ms_cnt_q + c_ms_w'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         us_cnt_q <= '0;
         ms_cnt_q <= '0;
      end else begin
         us_cnt_q <= us_cnt_d;
         ms_cnt_q <= ms_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/temp_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : temp_monitor
//  Purpose  : Schedules 1-wire temperature reads, averages them and raises alarms.
//  Revision : 1.0
// ============================================================================
module temp_monitor
   import temp_mon_pkg::*;
#(
   parameter int FCLK       = 125,
   parameter int US_PER_MS  = 1000,
   parameter int PERIOD_MS  = 1000,
   parameter int TIMEOUT_MS = 1000,
   parameter int T_HIGH     = 70,
   parameter int T_HYST     = 5
) (
   input  logic        clk,
   input  logic        rst,
   output logic        meas_start,
   input  logic        meas_done,
   input  logic [15:0] meas_raw,
   input  logic        meas_presence,
   output logic [7:0]  temp_c,
   output logic [7:0]  temp_avg,
   output logic        temp_valid,
   output logic        alarm,
   output logic        sensor_err,
   output logic [7:0]  err_cnt
);

   localparam logic [15:0]        c_period_last  = 16'(PERIOD_MS - 1);
   localparam logic [15:0]        c_timeout_last = 16'(TIMEOUT_MS - 1);
   localparam logic signed [9:0]  c_t_high       = 10'(T_HIGH);
   localparam logic signed [9:0]  c_t_clear      = 10'(T_HIGH - T_HYST);

   logic us_tick_w, ms_tick_w;

   temp_ms_timer #(.FCLK(FCLK), .US_PER_MS(US_PER_MS)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .us_tick (us_tick_w),
      .ms_tick (ms_tick_w)
   );

   state_t             state_q, state_d;
   logic [15:0]        ms_cnt_q, ms_cnt_d;
   logic [15:0]        raw_q, raw_d;
   logic               pres_q, pres_d;
   logic               first_q, first_d;
   logic signed [7:0]  win_q [4];
   logic signed [7:0]  win_d [4];
   logic               win_full_q, win_full_d;
   logic               avg_pend_q, avg_pend_d;
   logic               hyst_q, hyst_d;
   logic [1:0]         consec_q, consec_d;
   logic signed [7:0]  temp_c_q, temp_c_d;
   logic signed [7:0]  temp_avg_q, temp_avg_d;
   logic               temp_valid_q, temp_valid_d;
   logic               alarm_q, alarm_d;
   logic               sensor_err_q, sensor_err_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
   logic               meas_start_q, meas_start_d;

   logic signed [7:0]  conv_w;
   logic signed [9:0]  sum_w;
   logic signed [9:0]  avg10_w;
   logic signed [7:0]  avg_w;

   always_comb begin
      conv_w  = raw_to_c(raw_q);
      sum_w   = 10'(win_q[0]) + 10'(win_q[1]) + 10'(win_q[2]) + 10'(win_q[3]);
      avg10_w = sum_w >>> 2;
      avg_w   = avg10_w[7:0];
   end

   always_comb begin
      state_d      = state_q;
      ms_cnt_d     = ms_cnt_q;
      raw_d        = raw_q;
      pres_d       = pres_q;
      first_d      = first_q;
      win_d        = win_q;
      win_full_d   = win_full_q;
      avg_pend_d   = 1'b0;
      hyst_d       = hyst_q;
      consec_d     = consec_q;
      temp_c_d     = temp_c_q;
      temp_avg_d   = temp_avg_q;
      temp_valid_d = 1'b0;
      sensor_err_d = sensor_err_q;
      err_cnt_d    = err_cnt_q;
      meas_start_d = 1'b0;

      // Average is published one cycle after the window shifts.
      if (avg_pend_q) begin
         temp_avg_d   = avg_w;
         temp_valid_d = 1'b1;
         if (10'(avg_w) >= c_t_high)
            hyst_d = 1'b1;
         else if (10'(avg_w) <= c_t_clear)
            hyst_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (ms_tick_w) begin
               if (ms_cnt_q == c_period_last)
                  state_d = START;
               else
                  ms_cnt_d = ms_cnt_q + 16'd1;
            end
         end
         START: begin
            meas_start_d = 1'b1;
            ms_cnt_d     = '0;
            state_d      = WAIT;
         end
         WAIT: begin
            if (meas_done) begin
               raw_d   = meas_raw;
               pres_d  = meas_presence;
               state_d = PROC;
            end else if (ms_tick_w) begin
               if (ms_cnt_q == c_timeout_last)
                  state_d = FAIL;
               else
                  ms_cnt_d = ms_cnt_q + 16'd1;
            end
         end
         PROC: begin
            ms_cnt_d = '0;
            if (!pres_q)
               state_d = FAIL;
            else if (first_q && raw_q == RAW_POR) begin
               first_d = 1'b0;
               state_d = IDLE;
            end else
               state_d = UPDATE;
         end
         UPDATE: begin
            ms_cnt_d = '0;
            temp_c_d = conv_w;
            if (!win_full_q) begin
               for (int i = 0; i < 4; i++) win_d[i] = conv_w;
               win_full_d = 1'b1;
            end else begin
               win_d[0] = win_q[1];
               win_d[1] = win_q[2];
               win_d[2] = win_q[3];
               win_d[3] = conv_w;
            end
            avg_pend_d   = 1'b1;
            sensor_err_d = 1'b0;
            consec_d     = 2'd0;
            first_d      = 1'b0;
            state_d      = IDLE;
         end
         FAIL: begin
            ms_cnt_d     = '0;
            sensor_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (consec_q != 2'd3)   consec_d  = consec_q + 2'd1;
            state_d      = IDLE;
         end
         default: state_d = START;
      endcase

      alarm_d = hyst_d | (consec_d == 2'd3);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= START;
         ms_cnt_q     <= '0;
         raw_q        <= '0;
         pres_q       <= 1'b0;
         first_q      <= 1'b1;
         win_q        <= '{default: '0};
         win_full_q   <= 1'b0;
         avg_pend_q   <= 1'b0;
         hyst_q       <= 1'b0;
         consec_q     <= 2'd0;
         temp_c_q     <= '0;
         temp_avg_q   <= '0;
         temp_valid_q <= 1'b0;
         alarm_q      <= 1'b0;
         sensor_err_q <= 1'b0;
         err_cnt_q    <= '0;
         meas_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ms_cnt_q     <= ms_cnt_d;
         raw_q        <= raw_d;
         pres_q       <= pres_d;
         first_q      <= first_d;
         win_q        <= win_d;
         win_full_q   <= win_full_d;
         avg_pend_q   <= avg_pend_d;
         hyst_q       <= hyst_d;
         consec_q     <= consec_d;
         temp_c_q     <= temp_c_d;
         temp_avg_q   <= temp_avg_d;
         temp_valid_q <= temp_valid_d;
         alarm_q      <= alarm_d;
         sensor_err_q <= sensor_err_d;
         err_cnt_q    <= err_cnt_d;
         meas_start_q <= meas_start_d;
      end
   end

   assign meas_start = meas_start_q;
   assign temp_c     = temp_c_q;
   assign temp_avg   = temp_avg_q;
   assign temp_valid = temp_valid_q;
   assign alarm      = alarm_q;
   assign sensor_err = sensor_err_q;
   assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_temp_monitor
//  Purpose  : Scoreboard bench for temp_monitor with directed sensor readings.
//  Revision : 1.0
// ============================================================================
module tb_temp_monitor;
   import temp_mon_pkg::*;

   localparam int FCLK       = 2;
   localparam int US_PER_MS  = 4;
   localparam int PERIOD_MS  = 3;
   localparam int TIMEOUT_MS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        meas_start;
   logic        meas_done = 1'b0;
   logic [15:0] meas_raw = 16'h0000;
   logic        meas_presence = 1'b0;
   logic [7:0]  temp_c;
   logic [7:0]  temp_avg;
   logic        temp_valid;
   logic        alarm;
   logic        sensor_err;
   logic [7:0]  err_cnt;

   temp_monitor #(
      .FCLK(FCLK), .US_PER_MS(US_PER_MS), .PERIOD_MS(PERIOD_MS),
      .TIMEOUT_MS(TIMEOUT_MS), .T_HIGH(70), .T_HYST(5)
   ) dut (
      .clk(clk), .rst(rst), .meas_start(meas_start), .meas_done(meas_done),
      .meas_raw(meas_raw), .meas_presence(meas_presence), .temp_c(temp_c),
      .temp_avg(temp_avg), .temp_valid(temp_valid), .alarm(alarm),
      .sensor_err(sensor_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tc;
      int ta;
      int al;
      int se;
      int ec;
   } exp_t;

   exp_t valid_q[$];
   exp_t fail_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   function automatic void push_v(input int tc, input int ta, input int al, input int ec);
      exp_t e;
      e.tc = tc; e.ta = ta; e.al = al; e.se = 0; e.ec = ec;
      valid_q.push_back(e);
   endfunction

   function automatic void push_f(input int ec, input int al);
      exp_t e;
      e.tc = 0; e.ta = 0; e.al = al; e.se = 1; e.ec = ec;
      fail_q.push_back(e);
   endfunction

   // Monitor: successful samples show up as temp_valid, failures as an err_cnt step.
   logic [7:0] prev_ec = 8'h00;
   int         n_valid_seen = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst && temp_valid) begin
         n_valid_seen++;
         if (valid_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_valid: temp_c=%0d temp_avg=%0d, required no output",
                     $signed(temp_c), $signed(temp_avg));
         end else begin
            e = valid_q.pop_front();
            chk($sformatf("temp_c[%0d]", n_valid_seen),   $signed(temp_c),   e.tc);
            chk($sformatf("temp_avg[%0d]", n_valid_seen), $signed(temp_avg), e.ta);
            chk($sformatf("alarm_v[%0d]", n_valid_seen),  int'(alarm),       e.al);
            chk($sformatf("serr_v[%0d]", n_valid_seen),   int'(sensor_err),  e.se);
            chk($sformatf("errcnt_v[%0d]", n_valid_seen), int'(err_cnt),     e.ec);
         end
      end
      if (!rst && err_cnt != prev_ec) begin
         if (fail_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_err: err_cnt=%0d, required %0d", err_cnt, prev_ec);
         end else begin
            e = fail_q.pop_front();
            chk($sformatf("errcnt_f[%0d]", e.ec), int'(err_cnt),    e.ec);
            chk($sformatf("serr_f[%0d]", e.ec),   int'(sensor_err), e.se);
            chk($sformatf("alarm_f[%0d]", e.ec),  int'(alarm),      e.al);
            chk($sformatf("valid_f[%0d]", e.ec),  int'(temp_valid), 0);
         end
      end
      prev_ec = err_cnt;
   end

   task automatic wait_start();
      int  n;
      bit  seen;
      n = 0; seen = 1'b0;
      while (!seen && n < 300) begin
         @(negedge clk);
         n++;
         if (meas_start) seen = 1'b1;
      end
      if (!seen) begin
         n_tests++; n_fail++;
         $display("FAIL start_timeout: meas_start=0 after %0d cycles, required 1", n);
      end
   endtask

   task automatic drive_done(input logic [15:0] raw, input logic pres);
      repeat (2) @(negedge clk);
      meas_raw      = raw;
      meas_presence = pres;
      meas_done     = 1'b1;
      @(negedge clk);
      meas_done     = 1'b0;
   endtask

   task automatic reading(input logic [15:0] raw, input logic pres);
      wait_start();
      drive_done(raw, pres);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_meas_start"}, int'(meas_start), 0);
      chk({tag, "_temp_c"},     int'(temp_c),     0);
      chk({tag, "_temp_avg"},   int'(temp_avg),   0);
      chk({tag, "_temp_valid"}, int'(temp_valid), 0);
      chk({tag, "_alarm"},      int'(alarm),      0);
      chk({tag, "_sensor_err"}, int'(sensor_err), 0);
      chk({tag, "_err_cnt"},    int'(err_cnt),    0);
   endtask

   initial begin
      int  n;
      bit  seen;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (meas_start) seen = 1'b1;
      end
      chk("start_after_reset", int'(seen), 1);

      // Power-on 85 C reading is dropped; nothing pushed for it.
      drive_done(16'h0550, 1'b1);
      push_v(25, 25, 0, 0);  reading(16'h0191, 1'b1);

      push_v(70, 36, 0, 0);  reading(16'h0460, 1'b1);
      push_v(71, 47, 0, 0);  reading(16'h0470, 1'b1);
      push_v(72, 59, 0, 0);  reading(16'h0480, 1'b1);
      push_v(73, 71, 1, 0);  reading(16'h0490, 1'b1);
      push_v(64, 70, 1, 0);  reading(16'h0400, 1'b1);
      push_v(64, 68, 1, 0);  reading(16'h0400, 1'b1);
      push_v(64, 66, 1, 0);  reading(16'h0400, 1'b1);
      push_v(64, 64, 0, 0);  reading(16'h0400, 1'b1);

      push_v(-10, 45, 0, 0); reading(16'hFF5E, 1'b1);
      push_v(-55, 15, 0, 0); reading(16'hFC90, 1'b1);

      // Three timeouts in a row, then a good reading.
      push_f(1, 0);
      push_f(2, 0);
      push_f(3, 1);
      for (int i = 0; i < 3; i++) wait_start();
      push_v(25, 6, 0, 3);   reading(16'h0191, 1'b1);

      push_f(4, 0);          reading(16'h0191, 1'b0);

      // meas_done lands on the very ms tick that would time out.
      push_v(25, -4, 0, 4);
      wait_start();
      n = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         if (dut.state_q == WAIT && dut.ms_tick_w &&
             dut.ms_cnt_q == 16'(TIMEOUT_MS - 1))
            seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk("coincident_edge_found", int'(seen), 1);
      meas_raw = 16'h0191; meas_presence = 1'b1; meas_done = 1'b1;
      @(negedge clk);
      meas_done = 1'b0;

      // 85 C is only special for the first sample after reset.
      push_v(85, 20, 0, 4);  reading(16'h0550, 1'b1);

      // Reset mid-WAIT; a stray meas_done right at release must be ignored.
      wait_start();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_all_zero("midreset");
      push_f(1, 0);
      rst = 1'b0;
      meas_raw = 16'h0191; meas_presence = 1'b1; meas_done = 1'b1;
      @(negedge clk);
      meas_done = 1'b0;
      chk("start_after_midreset", int'(meas_start), 1);

      repeat (30) @(negedge clk);
      chk("pending_valid", valid_q.size(), 0);
      chk("pending_fail",  fail_q.size(),  0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/temp_monitor.md
Name: temp_monitor

Overview:
- Downstream consumer and scheduler for the 1-wire temperature reader.
- Periodically issues a measurement request, then waits for the raw DS18B20 reading with a timeout.
- Converts the raw reading to signed integer °C, keeps a 4-sample moving average, and drives an over-temperature alarm with hysteresis plus sensor-fault status.
- Sits between the 1-wire reader and the board control/telemetry logic.

Parameters:
- FCLK, 125: clk cycles per microsecond tick.
- US_PER_MS, 1000: microsecond ticks per millisecond tick; overridden small in simulation.
- PERIOD_MS, 1000: ms from end of one measurement to the next request.
- TIMEOUT_MS, 1000: max ms waiting for meas_done after meas_start.
- T_HIGH, 70: alarm set threshold, signed °C.
- T_HYST, 5: alarm clears at T_HIGH-T_HYST.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- meas_start  out  1  one-cycle request pulse to the 1-wire reader
- meas_done  in  1  one-cycle pulse; reading valid
- meas_raw  in  16  DS18B20 format: signed, 1/16 °C; sampled when meas_done=1
- meas_presence  in  1  sensor answered reset; sampled with meas_done
- temp_c  out  8  last converted temperature, signed °C
- temp_avg  out  8  4-sample average, signed °C
- temp_valid  out  1  one-cycle pulse when temp_c/temp_avg update
- alarm  out  1  over-temperature or persistent-fault alarm
- sensor_err  out  1  last measurement failed
- err_cnt  out  8  total failed measurements, saturating

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM=START; timers 0; average window empty; consec_err=0; first_sample=1.
- Tick generation:
  - us tick every FCLK cycles.
  - ms tick every US_PER_MS us ticks.
  - Tick counters free-run and are never cleared except by rst.
- FSM states:
  - IDLE: ms counter counts to PERIOD_MS, then go to START.
  - START: meas_start=1 for exactly one cycle, clear the ms counter, go to WAIT.
  - WAIT: meas_done=1 goes to PROC, capturing meas_raw and meas_presence. Otherwise, ms counter reaching TIMEOUT_MS goes to FAIL. If meas_done and timeout coincide, meas_done wins.
  - PROC: one cycle. Compute conv=(raw+8)>>>4 arithmetic in 17-bit signed, saturated to [-128,127]. If meas_presence=0, go to FAIL. If first_sample=1 and raw==16'h0550 (power-on 85 °C), discard: clear first_sample, no output change, go to IDLE. Otherwise go to UPDATE.
  - UPDATE: one cycle.
    - temp_c<=conv.
    - Window: if empty, preload all 4 entries with conv; else shift in conv.
    - temp_avg<=sum4>>>2, with sum in 10-bit signed, floor rounding, computed from the updated window and registered the next cycle.
    - temp_valid pulses in the cycle temp_avg updates.
    - sensor_err<=0; consec_err<=0; first_sample<=0.
    - Go to IDLE.
  - FAIL: one cycle. sensor_err<=1; err_cnt+=1, saturating at 255; consec_err+=1, saturating at 3. temp_c/temp_avg hold; no temp_valid. Go to IDLE.
- Alarm:
  - Evaluated when temp_avg updates: set if temp_avg>=T_HIGH; clear if temp_avg<=T_HIGH-T_HYST; otherwise hold.
  - Forced to 1 while consec_err==3. On the first good sample after that, re-evaluate normally.
- meas_done outside WAIT is ignored.
- Latency: meas_done to temp_c valid is 2 cycles; meas_done to temp_avg/temp_valid is 3 cycles.
- rst mid-WAIT: return to START; any pending meas_done from the reader is ignored until the next START.

Decomposition:
- Package temp_mon_pkg holds:
  - the FSM state enum (IDLE, START, WAIT, PROC, UPDATE, FAIL)
  - localparam RAW_POR=16'h0550
  - function raw_to_c (round and saturate)
- Sub-module temp_ms_timer (FCLK, US_PER_MS) outputs us_tick/ms_tick pulses; it is reusable by the 1-wire reader.

Test Plan:
Simulation parameters: FCLK=2, US_PER_MS=4, PERIOD_MS=3, TIMEOUT_MS=2.
- Reset release → meas_start pulses once within 2 cycles; all outputs 0.
- First reading raw=0x0550, presence=1 → discarded, no temp_valid. Next reading raw=0x0191 (25.06 °C) → temp_c=25, temp_avg=25, temp_valid=1, alarm=0.
- Readings 0x0460, 0x0470, 0x0480, 0x0490 (70, 71, 72, 73 °C) after a 25 °C window → temp_avg sequence 36, 47, 59, 71; alarm rises on avg=71. Then four readings 0x0400 (64 °C) → alarm clears only when avg<=65.
- Negative: raw=0xFF5E (-10.125 °C) → temp_c=-10 (0xF6). raw=0xFC90 (-55 °C) → temp_c=-55 (0xC9).
- No meas_done for TIMEOUT_MS → sensor_err=1, err_cnt=1. Three consecutive timeouts → alarm=1. Next good 25 °C reading → sensor_err=0, alarm=0, err_cnt stays 3.
- meas_presence=0 with meas_done → FAIL path, err_cnt+1. meas_done coincident with the timeout ms tick → treated as success.
